// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point compressor/decompressor pair.
package fp_pkg;

  localparam int unsigned EXP_W   = 3;
  localparam int unsigned MAN_W   = 4;
  localparam int unsigned OUT_W   = 12;
  localparam int unsigned MAX_MAG = 1920;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } dec_state_e;

  // Compressed word as produced by the encoder.
  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
  } fp_word_t;

endpackage

// File: rtl/mag_to_twos.sv
// Conditional negate: sign-magnitude to two's complement, W bits wide.
module mag_to_twos #(
  parameter int unsigned W = 12
) (
  input  logic         sign,
  input  logic [W-1:0] mag,
  output logic [W-1:0] twos_c
);

  always_comb begin
    twos_c = mag;
    if (sign) twos_c = (~mag) + W'(1);
  end

endmodule

// File: rtl/fp_decode.sv
// Sequential FP-to-linear decoder: D = (-1)^S * F * 2^E, one shift per cycle.
module fp_decode
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [EXP_W-1:0] E,
  input  logic [MAN_W-1:0] F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] D,
  output logic             norm_err
);

  dec_state_e       state, state_d;
  logic [OUT_W-1:0] mag;
  logic [EXP_W-1:0] cnt;
  logic             sign_r;
  logic [OUT_W-1:0] twos_c;
  logic             in_ready_d, out_valid_d;

  mag_to_twos #(.W(OUT_W)) u_negate (
    .sign   (sign_r),
    .mag    (mag),
    .twos_c (twos_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (in_valid) state_d = (E != '0) ? SHIFT : SIGN;
      SHIFT:   if (cnt == EXP_W'(1)) state_d = SIGN;
      SIGN:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track it exactly.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_d == IDLE) in_ready_d  = 1'b1;
    if (state_d == DONE) out_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mag       <= '0;
      cnt       <= '0;
      sign_r    <= 1'b0;
      D         <= '0;
      norm_err  <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      unique case (state)
        IDLE: if (in_valid) begin
          sign_r   <= S;
          cnt      <= E;
          mag      <= OUT_W'(F);
          norm_err <= (E != '0) && !F[MAN_W-1];
        end
        SHIFT: begin
          mag <= mag << 1;
          cnt <= cnt - EXP_W'(1);
        end
        SIGN:    D <= twos_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_decode.sv
// Randomized and directed checks of fp_decode against an arithmetic reference model.
module tb_fp_decode;
  import fp_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             S = 1'b0;
  logic [EXP_W-1:0] E = '0;
  logic [MAN_W-1:0] F = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] D;
  logic             norm_err;

  int n_checks = 0;
  int n_errors = 0;

  fp_decode dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .norm_err  (norm_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference value: plain signed arithmetic, wrapped to 12 bits.
  function automatic logic [11:0] ref_d(input logic s, input int e, input int f);
    int v;
    v = f * (1 << e);
    if (s) v = -v;
    return 12'(v);
  endfunction

  // Behavioural encoder: saturate, then pick the smallest exponent that fits F in 4 bits.
  function automatic fp_word_t encode(input int x);
    fp_word_t w;
    int m, e;
    m = (x < 0) ? -x : x;
    if (m > int'(MAX_MAG)) m = int'(MAX_MAG);
    e = 0;
    while ((m >> e) > 15) e++;
    w.s = (x < 0);
    w.e = 3'(e);
    w.f = 4'(m >> e);
    return w;
  endfunction

  // One conversion from IDLE back to IDLE. Latency counts the accept cycle as cycle 1.
  task automatic run_one(input logic s, input logic [2:0] e, input logic [3:0] f,
                         input int hold, output logic [11:0] got_d);
    logic [11:0] exp_d;
    logic        exp_ne;
    int          lat;
    exp_d  = ref_d(s, int'(e), int'(f));
    exp_ne = (e != 0) && (f < 4'd8);
    check("idle_ready", 32'(in_ready), 32'd1);
    S = s; E = e; F = f; in_valid = 1'b1;
    out_ready = 1'($urandom);
    @(posedge clk); #1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom); S = 1'($urandom); E = 3'($urandom); F = 4'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("latency", 32'(lat), 32'(int'(e) + 2));
    check("d", 32'(D), 32'(exp_d));
    check("norm_err", 32'(norm_err), 32'(exp_ne));
    check("busy_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      S = 1'($urandom); E = 3'($urandom); F = 4'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_d", 32'(D), 32'(exp_d));
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    got_d = D;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ack_valid", 32'(out_valid), 32'd0);
    check("ack_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [11:0] d;
    fp_word_t    w;
    int          dv, bound, diff, m;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(D), 32'd0);
    check("rst_norm", 32'(norm_err), 32'd0);

    // Directed corner cases.
    run_one(1'b0, 3'd0, 4'd0, 0, d);
    run_one(1'b0, 3'd7, 4'd15, 0, d);
    check("max_pos", 32'(d), 32'h780);
    run_one(1'b1, 3'd7, 4'd15, 0, d);
    check("max_neg", 32'(d), 32'h880);
    run_one(1'b1, 3'd3, 4'd13, 0, d);
    check("neg104", 32'(d), 32'hF98);
    run_one(1'b1, 3'd0, 4'd0, 0, d);
    check("neg_zero", 32'(d), 32'h000);
    run_one(1'b0, 3'd2, 4'd5, 0, d);
    check("denorm_d", 32'(d), 32'd20);
    run_one(1'b0, 3'd1, 4'd8, 5, d);
    check("backpressure_d", 32'(d), 32'h010);

    // Reset in the middle of a long shift discards the conversion.
    S = 1'b1; E = 3'd6; F = 4'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_d", 32'(D), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    run_one(1'b0, 3'd1, 4'd8, 0, d);
    check("after_rst_d", 32'(d), 32'h010);

    // Random words with random backpressure.
    for (int i = 0; i < 300; i++)
      run_one(1'($urandom), 3'($urandom), 4'($urandom), int'($urandom_range(0, 3)), d);

    // Round trip of every 12-bit sample through the behavioural encoder.
    for (int x = -2048; x < 2048; x++) begin
      w = encode(x);
      run_one(w.s, w.e, w.f, 0, d);
      dv = int'($signed(d));
      m  = (x < 0) ? -x : x;
      bound = (1 << int'(w.e)) - 1;
      if (m > int'(MAX_MAG)) bound += m - int'(MAX_MAG);
      diff = (x > dv) ? x - dv : dv - x;
      check("roundtrip_err", 32'(diff <= bound), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
